// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: instruction codes, special register indices and
// retirement status values.
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;  // also cmovxx
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] RSP   = 4'h4;
  localparam logic [3:0] RNONE = 4'hF;

  typedef enum logic [1:0] {
    S_AOK = 2'd0,
    S_HLT = 2'd1,
    S_ADR = 2'd2,
    S_INS = 2'd3
  } stat_e;

endpackage

// File: rtl/regfile_2w2r.sv
// Register-file storage: two write ports (M port wins on a shared index),
// two combinational read ports plus a combinational debug read port.
module regfile_2w2r
  import y86_pkg::*;
#(
  parameter int          NREGS   = 15,
  parameter logic [63:0] SP_INIT = 64'd32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we_e,
  input  logic [3:0]  dst_e,
  input  logic [63:0] val_e,
  input  logic        we_m,
  input  logic [3:0]  dst_m,
  input  logic [63:0] val_m,
  input  logic [3:0]  src_a,
  input  logic [3:0]  src_b,
  input  logic [3:0]  src_c,
  output logic [63:0] rd_a,
  output logic [63:0] rd_b,
  output logic [63:0] rd_c
);

  logic [63:0] regs_q [NREGS];
  logic [63:0] regs_d [NREGS];

  function automatic logic idx_ok(input logic [3:0] idx);
    return (idx != RNONE) && (int'(idx) < NREGS);
  endfunction

  // Next array contents: E write first, then M write so M wins a shared index.
  always_comb begin
    // NOTE: the whole array is defaulted to its current value before the
    // conditional writes, so no path leaves an element unassigned (no latch).
    regs_d = regs_q;
    if (we_e && idx_ok(dst_e)) regs_d[dst_e] = val_e;
    if (we_m && idx_ok(dst_m)) regs_d[dst_m] = val_m;
  end

  // Array state register with architectural reset values.
  always_ff @(posedge clk) begin
    // NOTE: this array is architectural state that software reads right after
    // reset (%rsp must hold SP_INIT), so it is reset element by element rather
    // than left to power-up contents like a plain RAM.
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        // NOTE: state is only ever updated with non-blocking assignments, so
        // every reader in the same edge sees the pre-edge value.
        regs_q[i] <= (i == int'(RSP)) ? SP_INIT : 64'd0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Combinational reads; RNONE and out-of-range indices read as zero.
  always_comb begin
    rd_a = idx_ok(src_a) ? regs_q[src_a] : 64'd0;
    rd_b = idx_ok(src_b) ? regs_q[src_b] : 64'd0;
    rd_c = idx_ok(src_c) ? regs_q[src_c] : 64'd0;
  end

endmodule

// File: rtl/wb_regfile.sv
// Y86-64 sequential write-back stage: destination decode, commit gating,
// sticky halt latch and committed-write counter around the register file.
module wb_regfile
  import y86_pkg::*;
#(
  parameter int          NREGS   = 15,
  parameter logic [63:0] SP_INIT = 64'd32,
  parameter int          CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wb_valid,
  input  logic [3:0]       icode,
  input  logic [3:0]       rA,
  input  logic [3:0]       rB,
  input  logic             cnd,
  input  logic [63:0]      valE,
  input  logic [63:0]      valM,
  input  logic [1:0]       stat,
  input  logic [3:0]       srcA,
  input  logic [3:0]       srcB,
  output logic [63:0]      rdA,
  output logic [63:0]      rdB,
  input  logic [3:0]       dbg_sel,
  output logic [63:0]      dbg_val,
  output logic             halted,
  output logic [CNT_W-1:0] wr_count
);

  logic [3:0]       dst_e;
  logic [3:0]       dst_m;
  logic             commit;
  logic [1:0]       n_wr;
  logic             halted_q,   halted_d;
  logic [CNT_W-1:0] wr_count_q, wr_count_d;

  // Destination decode, commit gating and next halt/counter values.
  always_comb begin
    dst_e = RNONE;
    dst_m = RNONE;
    case (icode)
      I_RRMOVQ:                       dst_e = cnd ? rB : RNONE;
      I_IRMOVQ, I_OPQ:                dst_e = rB;
      I_CALL, I_RET, I_PUSHQ, I_POPQ: dst_e = RSP;
      default:                        dst_e = RNONE;
    endcase
    if (icode == I_MRMOVQ || icode == I_POPQ) dst_m = rA;

    commit = wb_valid && (stat == S_AOK) && !halted_q;

    // A shared destination is one write (valM), so count distinct registers.
    n_wr = 2'(dst_e != RNONE) + 2'(dst_m != RNONE)
         - 2'((dst_e == dst_m) && (dst_e != RNONE));

    halted_d   = halted_q | (wb_valid && (stat != S_AOK));
    wr_count_d = commit ? wr_count_q + CNT_W'(n_wr) : wr_count_q;
  end

  // Halt latch and write counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      halted_q   <= 1'b0;
      wr_count_q <= '0;
    end else begin
      halted_q   <= halted_d;
      wr_count_q <= wr_count_d;
    end
  end

  regfile_2w2r #(
    .NREGS   (NREGS),
    .SP_INIT (SP_INIT)
  ) u_rf (
    .clk   (clk),
    .rst_n (rst_n),
    .we_e  (commit),
    .dst_e (dst_e),
    .val_e (valE),
    .we_m  (commit),
    .dst_m (dst_m),
    .val_m (valM),
    .src_a (srcA),
    .src_b (srcB),
    .src_c (dbg_sel),
    .rd_a  (rdA),
    .rd_b  (rdB),
    .rd_c  (dbg_val)
  );

  assign halted   = halted_q;
  assign wr_count = wr_count_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed scenarios with literal
// expectations plus randomized retirement traffic against a behavioural model.
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_valid;
  logic [3:0]  icode, rA, rB;
  logic        cnd;
  logic [63:0] valE, valM;
  logic [1:0]  stat;
  logic [3:0]  srcA, srcB, dbg_sel;
  logic [63:0] rdA, rdB, dbg_val;
  logic        halted;
  logic [31:0] wr_count;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  // Behavioural model of the architectural state.
  logic [63:0] m_regs [15];
  bit          m_halted;
  logic [31:0] m_count;

  wb_regfile #(.NREGS(15), .SP_INIT(64'd32), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .wb_valid(wb_valid), .icode(icode),
    .rA(rA), .rB(rB), .cnd(cnd), .valE(valE), .valM(valM), .stat(stat),
    .srcA(srcA), .srcB(srcB), .rdA(rdA), .rdB(rdB),
    .dbg_sel(dbg_sel), .dbg_val(dbg_val), .halted(halted), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] m_read(input logic [3:0] idx);
    return (idx == 4'hF) ? 64'd0 : m_regs[idx];
  endfunction

  // Model: apply the retirement rules of the instruction presented at this edge.
  always @(posedge clk) begin
    logic [3:0] e, m;
    bit [15:0]  written;
    if (!rst_n) begin
      foreach (m_regs[i]) m_regs[i] = 64'd0;
      m_regs[4] = 64'd32;
      m_halted  = 1'b0;
      m_count   = 32'd0;
    end else if (wb_valid) begin
      if (stat != 2'd0) begin
        m_halted = 1'b1;
      end else if (!m_halted) begin
        e = 4'hF;
        m = 4'hF;
        if (icode == 4'h2 && cnd)                    e = rB;
        if (icode == 4'h3 || icode == 4'h6)          e = rB;
        if (icode inside {4'h8, 4'h9, 4'hA, 4'hB})   e = 4'h4;
        if (icode == 4'h5 || icode == 4'hB)          m = rA;
        written = '0;
        if (e != 4'hF) begin m_regs[e] = valE; written[e] = 1'b1; end
        if (m != 4'hF) begin m_regs[m] = valM; written[m] = 1'b1; end
        m_count = m_count + 32'($countones(written));
      end
    end
  end

  // Compare process: every negedge once the model is initialised.
  always @(negedge clk) begin
    if (chk_en) begin
      check("cmp_rdA",      rdA,      m_read(srcA));
      check("cmp_rdB",      rdB,      m_read(srcB));
      check("cmp_dbg_val",  dbg_val,  m_read(dbg_sel));
      check("cmp_halted",   64'(halted),   64'(m_halted));
      check("cmp_wr_count", 64'(wr_count), 64'(m_count));
    end
  end

  task automatic drive(input bit v, input logic [3:0] ic, input logic [3:0] a,
                       input logic [3:0] b, input bit c, input logic [63:0] e,
                       input logic [63:0] m, input logic [1:0] s);
    wb_valid = v; icode = ic; rA = a; rB = b; cnd = c;
    valE = e; valM = m; stat = s;
  endtask

  // Present the current inputs across one rising edge, then idle the port.
  task automatic step();
    @(posedge clk);
    #1;
    wb_valid = 1'b0;
  endtask

  task automatic peek(input string name, input logic [3:0] idx, input logic [63:0] exp);
    dbg_sel = idx;
    #1;
    check(name, dbg_val, exp);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    logic [63:0] r5;
    logic [31:0] cnt;
    rst_n = 1'b0;
    drive(1'b0, 4'h1, 4'hF, 4'hF, 1'b0, '0, '0, 2'd0);
    srcA = 4'h0; srcB = 4'h0; dbg_sel = 4'h0;

    // Reset
    step();
    step();
    rst_n  = 1'b1;
    chk_en = 1'b1;
    for (int i = 0; i < 16; i++)
      peek("reset_reg", 4'(i), (i == 4) ? 64'd32 : 64'd0);
    check("reset_halted", 64'(halted), 64'd0);
    check("reset_count",  64'(wr_count), 64'd0);

    // OPq rB=2 valE=-90
    drive(1'b1, 4'h6, 4'hF, 4'h2, 1'b0, 64'hFFFF_FFFF_FFFF_FFA6, 64'd0, 2'd0);
    step();
    srcB = 4'h2;
    #1;
    check("opq_rdB",   rdB, 64'hFFFF_FFFF_FFFF_FFA6);
    check("opq_count", 64'(wr_count), 64'd1);

    // cmovxx not taken
    drive(1'b1, 4'h2, 4'h0, 4'h3, 1'b0, 64'd11, 64'd0, 2'd0);
    step();
    peek("cmov_nt_reg3", 4'h3, 64'd0);
    check("cmov_nt_count", 64'(wr_count), 64'd1);

    // popq %rsp: valM wins, single write
    drive(1'b1, 4'hB, 4'h4, 4'hF, 1'b0, 64'd40, 64'd77, 2'd0);
    step();
    peek("popq_rsp_reg4", 4'h4, 64'd77);
    check("popq_rsp_count", 64'(wr_count), 64'd2);

    // popq %rcx: two distinct writes
    drive(1'b1, 4'hB, 4'h1, 4'hF, 1'b0, 64'd48, 64'd5, 2'd0);
    step();
    peek("popq_reg1", 4'h1, 64'd5);
    peek("popq_reg4", 4'h4, 64'd48);
    check("popq_count", 64'(wr_count), 64'd4);

    // Read during write: old value before the edge, new after
    srcA = 4'h2;
    drive(1'b1, 4'h3, 4'hF, 4'h2, 1'b0, 64'd99, 64'd0, 2'd0);
    #1;
    check("rdw_before", rdA, 64'hFFFF_FFFF_FFFF_FFA6);
    step();
    check("rdw_after", rdA, 64'd99);

    // Randomized AOK traffic
    for (int n = 0; n < 600; n++) begin
      drive(($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
            4'($urandom), 4'($urandom), 1'($urandom),
            {$urandom, $urandom}, {$urandom, $urandom}, 2'd0);
      srcA = 4'($urandom); srcB = 4'($urandom); dbg_sel = 4'($urandom);
      step();
    end

    // Halt: faulting mrmovq is suppressed, later writes blocked
    dbg_sel = 4'h5;
    #1;
    r5  = m_read(4'h5);
    cnt = m_count;
    drive(1'b1, 4'h5, 4'h5, 4'hF, 1'b0, 64'd0, 64'd123, 2'd2);
    step();
    peek("halt_reg5", 4'h5, r5);
    check("halt_flag", 64'(halted), 64'd1);
    drive(1'b1, 4'h3, 4'hF, 4'h5, 1'b0, 64'd7, 64'd0, 2'd0);
    step();
    peek("halt_block_reg5", 4'h5, r5);
    check("halt_block_count", 64'(wr_count), 64'(cnt));
    for (int n = 0; n < 40; n++) begin
      drive(1'b1, 4'($urandom_range(0, 11)), 4'($urandom), 4'($urandom),
            1'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
            2'($urandom));
      srcA = 4'($urandom); srcB = 4'($urandom); dbg_sel = 4'($urandom);
      step();
    end

    // Mid-run reset overrides a simultaneous write
    rst_n = 1'b0;
    drive(1'b1, 4'h3, 4'hF, 4'h6, 1'b0, 64'd55, 64'd0, 2'd0);
    step();
    rst_n = 1'b1;
    peek("mrst_reg6", 4'h6, 64'd0);
    peek("mrst_reg4", 4'h4, 64'd32);
    check("mrst_halted", 64'(halted), 64'd0);
    check("mrst_count",  64'(wr_count), 64'd0);

    // Post-reset random traffic including faults
    for (int n = 0; n < 200; n++) begin
      drive(1'($urandom), 4'($urandom_range(0, 15)), 4'($urandom), 4'($urandom),
            1'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
            ($urandom_range(0, 40) == 0) ? 2'd3 : 2'd0);
      srcA = 4'($urandom); srcB = 4'($urandom); dbg_sel = 4'($urandom);
      step();
    end

    @(posedge clk);
    #1;
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
